// File: rtl/sw_debouncer.sv
// Slide-switch conditioner: 2-FF synchroniser, tick-based debounce FSM, rise/fall pulses.
// Optional direction toggle register built only when SW_DEBOUNCE_TOGGLE_EN is defined.
module sw_debouncer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic sw_db,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW   = $clog2(STABLE_TICKS + 1);

  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]   CntLast  = CntW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    StIdleLo,
    StWaitHi,
    StIdleHi,
    StWaitLo
  } state_e;

  logic              s1_q, s2_q;
  logic [PrescW-1:0] presc_q;
  logic [CntW-1:0]   cnt_q;
  state_e            state_q;
  logic              sw_db_q, rise_q, fall_q;
  logic              tick;

  // Two-flop synchroniser; the FSM only ever looks at s2_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
    end
  end

  // Free-running prescaler, independent of FSM activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PrescW'(1);
    end
  end

  assign tick = (presc_q == PrescMax);

  `ifdef SW_DEBOUNCE_TOGGLE_EN
  logic toggle_q;
  `endif

  // Bounce is checked before the final tick so a coincident bounce wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdleLo;
      cnt_q    <= '0;
      sw_db_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      `ifdef SW_DEBOUNCE_TOGGLE_EN
      toggle_q <= 1'b0;
      `endif
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        StIdleLo: begin
          if (s2_q) begin
            state_q <= StWaitHi;
            cnt_q   <= '0;
          end
        end
        StWaitHi: begin
          if (!s2_q) begin
            state_q <= StIdleLo;
          end else if (tick && (cnt_q == CntLast)) begin
            state_q  <= StIdleHi;
            sw_db_q  <= 1'b1;
            rise_q   <= 1'b1;
            `ifdef SW_DEBOUNCE_TOGGLE_EN
            toggle_q <= ~toggle_q;
            `endif
          end else if (tick) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StIdleHi: begin
          if (!s2_q) begin
            state_q <= StWaitLo;
            cnt_q   <= '0;
          end
        end
        StWaitLo: begin
          if (s2_q) begin
            state_q <= StIdleHi;
          end else if (tick && (cnt_q == CntLast)) begin
            state_q <= StIdleLo;
            sw_db_q <= 1'b0;
            fall_q  <= 1'b1;
          end else if (tick) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdleLo;
        end
      endcase
    end
  end

  assign sw_db = sw_db_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

  `ifdef SW_DEBOUNCE_TOGGLE_EN
  assign toggle = toggle_q;
  `else
  assign toggle = 1'b0;
  `endif

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with TICK_DIV=4, STABLE_TICKS=3, 10 ns clock.
module tb_sw_debouncer;

  `ifdef SW_DEBOUNCE_TOGGLE_EN
  localparam bit ToggleEn = 1'b1;
  `else
  localparam bit ToggleEn = 1'b0;
  `endif

  logic clk = 1'b0;
  logic reset;
  logic sw;
  logic sw_db, rise, fall, toggle;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned rise_cnt = 0, fall_cnt = 0, both_cnt = 0, db_hi_cnt = 0;

  sw_debouncer #(
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .sw_db  (sw_db),
    .rise   (rise),
    .fall   (fall),
    .toggle (toggle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rise === 1'b1) rise_cnt++;
    if (fall === 1'b1) fall_cnt++;
    if (rise === 1'b1 && fall === 1'b1) both_cnt++;
    if (sw_db === 1'b1) db_hi_cnt++;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of clocks until sw_db reaches lvl, or 0 on timeout.
  task automatic wait_db(input logic lvl, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (sw_db === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int unsigned r0, f0, d0, bad;

    // 1: reset and idle
    sw    = 1'b0;
    reset = 1'b1;
    tick_clk(3);
    check("rst_sw_db", sw_db, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_toggle", toggle, 0);
    reset = 1'b0;
    r0 = rise_cnt; f0 = fall_cnt; d0 = db_hi_cnt;
    tick_clk(50);
    check("idle_rise", rise_cnt - r0, 0);
    check("idle_fall", fall_cnt - f0, 0);
    check("idle_db_hi", db_hi_cnt - d0, 0);

    // 2: clean press
    r0 = rise_cnt; f0 = fall_cnt;
    sw = 1'b1;
    wait_db(1'b1, n);
    check("press_lat_ok", (n >= 12 && n <= 15) ? 1 : 0, 1);
    check("press_rise_hi", rise, 1);
    tick_clk(1);
    check("press_rise_width", rise, 0);
    tick_clk(2);
    check("press_toggle", toggle, ToggleEn ? 1 : 0);
    check("press_rise_cnt", rise_cnt - r0, 1);
    check("press_fall_cnt", fall_cnt - f0, 0);

    // 3: bouncing release, then clean low
    r0 = rise_cnt; f0 = fall_cnt; bad = 0;
    for (int i = 0; i < 14; i++) begin
      sw = ~sw;
      for (int k = 0; k < 2; k++) begin
        tick_clk(1);
        if (sw_db !== 1'b1) bad++;
      end
    end
    check("bounce_db_held", bad, 0);
    check("bounce_no_fall", fall_cnt - f0, 0);
    sw = 1'b0;
    wait_db(1'b0, n);
    check("release_lat_ok", (n >= 12 && n <= 15) ? 1 : 0, 1);
    check("release_fall_hi", fall, 1);
    tick_clk(1);
    check("release_fall_width", fall, 0);
    check("release_fall_cnt", fall_cnt - f0, 1);
    check("release_rise_cnt", rise_cnt - r0, 0);

    // 4: short glitches never qualify
    r0 = rise_cnt;
    for (int i = 0; i < 4; i++) begin
      sw = 1'b1;
      tick_clk(5);
      sw = 1'b0;
      tick_clk(10);
    end
    tick_clk(20);
    check("glitch_rise_cnt", rise_cnt - r0, 0);
    check("glitch_sw_db", sw_db, 0);

    // 5: reset while in WAIT_HI with sw held high
    r0 = rise_cnt; f0 = fall_cnt;
    sw = 1'b1;
    tick_clk(5);
    reset = 1'b1;
    tick_clk(1);
    check("midrst_sw_db", sw_db, 0);
    check("midrst_rise", rise, 0);
    check("midrst_toggle", toggle, 0);
    check("midrst_no_pulse", rise_cnt - r0, 0);
    reset = 1'b0;
    wait_db(1'b1, n);
    check("midrst_lat_ok", (n >= 12 && n <= 15) ? 1 : 0, 1);
    tick_clk(20);
    check("midrst_rise_cnt", rise_cnt - r0, 1);
    check("midrst_fall_cnt", fall_cnt - f0, 0);

    // 6: two press/release cycles for toggle
    sw    = 1'b0;
    reset = 1'b1;
    tick_clk(2);
    reset = 1'b0;
    check("tgl_start", toggle, 0);
    for (int p = 0; p < 2; p++) begin
      sw = 1'b1;
      wait_db(1'b1, n);
      check("tgl_press_lat_ok", (n >= 12 && n <= 15) ? 1 : 0, 1);
      tick_clk(2);
      check("tgl_after_press", toggle, (ToggleEn && p == 0) ? 1 : 0);
      sw = 1'b0;
      wait_db(1'b0, n);
      check("tgl_release_lat_ok", (n >= 12 && n <= 15) ? 1 : 0, 1);
      tick_clk(2);
      check("tgl_after_release", toggle, (ToggleEn && p == 0) ? 1 : 0);
    end

    check("rise_fall_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
